reaction_round_ctrl: RTL and testbench
======================================

Name: reaction_round_ctrl

Overview:
Sequences one reaction-timer round: random pre-delay, stimulus, timed response, result capture and best-score tracking.
Drives the external 1 kHz BCD reaction counter (clear/enable) and owns the 6-digit display source select (score / best / scroll message).
Sits between the debouncers, LFSR, BCD counter and the BCD-to-7-seg decoders in the top level.

Parameters:
DELAY_MIN, 1000, fixed ms added to the LFSR value to form the pre-delay
LFSR_W, 13, width of the random delay input
TIMEOUT_BCD, 12'h999, score at which a round is auto-terminated

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick_1ms  in  1  one-cycle 1 kHz enable, synchronous to board_clk
start  in  1  debounced start/stop, one-cycle pulse
clear_best  in  1  one-cycle pulse, resets best score
lfsr_val  in  LFSR_W  random value, sampled in ARM
score_bcd  in  12  live 3-digit BCD from reaction counter
gb_bcd  in  24  scroll-message digits
hs_switch  in  1  show best score
gb_switch  in  1  show scroll message (hs_switch has priority)
timer_clr  out  1  one-cycle clear to reaction counter
timer_en  out  1  reaction counter count enable
LED  out  10  stimulus/status LEDs
disp_bcd  out  24  six BCD digits to decoders; 4'hF = blank
decimal_pt  out  1  active-low decimal point
best_bcd  out  12  best (lowest) score
round_done  out  1  one-cycle pulse when a result is captured
timeout  out  1  high in DONE if round ended by TIMEOUT_BCD

Behaviour:
- Reset: state IDLE, delay count 0, timer_clr=0, timer_en=0, LED=0, best_bcd=12'h999, round_done=0, timeout=0, disp_bcd={12'hFFF,12'h000}, decimal_pt=0.
- All outputs registered (Moore); state change takes effect on the edge after the causing input is sampled.
- IDLE: start -> ARM.
- ARM (1 cycle): load delay = lfsr_val + DELAY_MIN (LFSR_W+1 bits, no overflow); timer_clr=1; -> WAIT. start ignored.
- WAIT: decrement delay on each tick_1ms; LED=0; the cycle the count is 0 -> TIMING.
- TIMING: timer_en=1, LED=10'h3FF. start -> DONE (timer_en low next edge, at most one extra count). score_bcd==TIMEOUT_BCD -> DONE with timeout=1.
- DONE entry: capture score_bcd into result register; round_done pulses 1 cycle; if result < best_bcd (unsigned compare valid for BCD), best_bcd <= result, except timeout rounds never update best. LED=10'h001, or 10'h2AA on timeout. start -> ARM (new round; timeout cleared).
- Simultaneous: start + delay expiry in WAIT -> see optional feature; start + timeout in TIMING -> start wins, timeout=0; clear_best + best update same cycle -> clear wins (12'h999).
- Display (1-cycle registered): hs_switch=1 -> {12'hFFF,best_bcd}, dp=0; else gb_switch=1 -> gb_bcd, dp=1; else {12'hFFF, TIMING ? score_bcd : result}, dp=0.
- reset asserted mid-round: immediate return to reset values; best score lost.

Optional Feature:
FALSE_START_EN: defined -> start in WAIT (including on expiry cycle) goes to DONE with result forced to TIMEOUT_BCD, timeout=1, LED=10'h2AA, best not updated, timer never enabled. Undefined -> start in WAIT ignored; round continues.

Decomposition:
- Shared package rt_pkg: state enum (IDLE, ARM, WAIT, TIMING, DONE), BLANK_DIGIT=4'hF, LED_ALL/LED_DONE/LED_FAULT patterns, default TIMEOUT_BCD.
- One sub-module: reaction_delay_cnt (load, tick-decrement, zero flag).

Test Plan:
- reset low, release -> best_bcd=12'h999, LED=0, disp_bcd=24'hFFF000, timer_en=0.
- lfsr_val=5, DELAY_MIN=10, start -> timer_clr 1 cycle, TIMING after exactly 15 ticks, LED=10'h3FF.
- Counter driven to 12'h234, start -> round_done 1 pulse, best_bcd=12'h234; next round 12'h300 -> best stays 12'h234.
- No response, score_bcd reaches 12'h999 -> DONE, timeout=1, LED=10'h2AA, best unchanged.
- FALSE_START_EN defined, start 3 ticks into WAIT -> DONE, result 12'h999, timer_en never high; undefined -> stays WAIT.
- hs_switch=1,gb_switch=1 -> best shown, dp=0; hs=0,gb=1 -> gb_bcd, dp=1; clear_best with concurrent update -> 12'h999.

Source files
------------

// File: rtl/reaction_round_ctrl_pkg.sv
// Shared types and constants for the reaction-timer round controller.
package rt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    TIMING,
    DONE
  } state_t;

  localparam logic [3:0]  BLANK_DIGIT         = 4'hF;
  localparam logic [11:0] BLANK3              = {3{BLANK_DIGIT}};
  localparam logic [9:0]  LED_OFF             = 10'h000;
  localparam logic [9:0]  LED_ALL             = 10'h3FF;
  localparam logic [9:0]  LED_DONE            = 10'h001;
  localparam logic [9:0]  LED_FAULT           = 10'h2AA;
  localparam logic [11:0] DEFAULT_TIMEOUT_BCD = 12'h999;
  localparam logic [11:0] BEST_RESET          = 12'h999;

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Signal bundle between the round controller and its surroundings
// (debouncers, LFSR, BCD reaction counter, 7-seg decoders).
interface reaction_round_ctrl_if #(
  parameter int unsigned LFSR_W = 13
);
  logic              tick_1ms;
  logic              start;
  logic              clear_best;
  logic [LFSR_W-1:0] lfsr_val;
  logic [11:0]       score_bcd;
  logic [23:0]       gb_bcd;
  logic              hs_switch;
  logic              gb_switch;

  logic              timer_clr;
  logic              timer_en;
  logic [9:0]        LED;
  logic [23:0]       disp_bcd;
  logic              decimal_pt;
  logic [11:0]       best_bcd;
  logic              round_done;
  logic              timeout;

  modport master (
    output tick_1ms, start, clear_best, lfsr_val, score_bcd, gb_bcd,
           hs_switch, gb_switch,
    input  timer_clr, timer_en, LED, disp_bcd, decimal_pt, best_bcd,
           round_done, timeout
  );

  modport slave (
    input  tick_1ms, start, clear_best, lfsr_val, score_bcd, gb_bcd,
           hs_switch, gb_switch,
    output timer_clr, timer_en, LED, disp_bcd, decimal_pt, best_bcd,
           round_done, timeout
  );
endinterface

// File: rtl/reaction_round_ctrl_delay_cnt.sv
// Pre-delay down-counter: loads the random delay, decrements on each 1 ms
// tick while running, and flags zero.
module reaction_delay_cnt #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] count;

  assign zero = (count == '0);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && tick && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round sequencer with best-score tracking and display select.
// Optional macro FALSE_START_EN: start during the pre-delay ends the round as a fault.
module reaction_round_ctrl
  import rt_pkg::*;
#(
  parameter int unsigned DELAY_MIN   = 1000,
  parameter int unsigned LFSR_W      = 13,
  parameter logic [11:0] TIMEOUT_BCD = DEFAULT_TIMEOUT_BCD
) (
  input  logic                board_clk,
  input  logic                reset,
  reaction_round_ctrl_if.slave bus
);

  localparam int unsigned        CNT_W       = LFSR_W + 1;
  localparam logic [CNT_W-1:0]   DELAY_MIN_C = CNT_W'(DELAY_MIN);

  state_t           state, next_state;
  logic             delay_zero;
  logic             false_start;
  logic             cap_result, cap_timeout, next_timeout;
  logic [11:0]      cap_value;
  logic [11:0]      result, best;
  logic [CNT_W-1:0] load_val;

  logic             timer_clr_q, timer_en_q, round_done_q, timeout_q, dp_q;
  logic [9:0]       led_q;
  logic [23:0]      disp_q;

  assign load_val = {1'b0, bus.lfsr_val} + DELAY_MIN_C;

`ifdef FALSE_START_EN
  assign false_start = bus.start;
`else
  assign false_start = 1'b0;
`endif

  reaction_delay_cnt #(.W(CNT_W)) u_delay (
    .clk      (board_clk),
    .rst_n    (reset),
    .load     (state == ARM),
    .load_val (load_val),
    .run      (state == WAIT),
    .tick     (bus.tick_1ms),
    .zero     (delay_zero)
  );

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    cap_result  = 1'b0;
    cap_timeout = 1'b0;
    cap_value   = bus.score_bcd;
    case (state)
      IDLE:   if (bus.start) next_state = ARM;
      ARM:    next_state = WAIT;
      WAIT: begin
        if (false_start) begin
          next_state  = DONE;
          cap_result  = 1'b1;
          cap_timeout = 1'b1;
          cap_value   = TIMEOUT_BCD;
        end else if (delay_zero) begin
          next_state = TIMING;
        end
      end
      TIMING: begin
        // A press on the same cycle as the timeout count is a valid response.
        if (bus.start) begin
          next_state = DONE;
          cap_result = 1'b1;
        end else if (bus.score_bcd == TIMEOUT_BCD) begin
          next_state  = DONE;
          cap_result  = 1'b1;
          cap_timeout = 1'b1;
        end
      end
      DONE:   if (bus.start) next_state = ARM;
      default: next_state = IDLE;
    endcase

    if (cap_result)              next_timeout = cap_timeout;
    else if (next_state == DONE) next_timeout = timeout_q;
    else                         next_timeout = 1'b0;
  end

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      timer_clr_q  <= 1'b0;
      timer_en_q   <= 1'b0;
      round_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      led_q        <= LED_OFF;
      result       <= '0;
      best         <= BEST_RESET;
      disp_q       <= {BLANK3, 12'h000};
      dp_q         <= 1'b0;
    end else begin
      timer_clr_q  <= (next_state == ARM);
      timer_en_q   <= (next_state == TIMING);
      round_done_q <= cap_result;
      timeout_q    <= next_timeout;

      case (next_state)
        TIMING:  led_q <= LED_ALL;
        DONE:    led_q <= next_timeout ? LED_FAULT : LED_DONE;
        default: led_q <= LED_OFF;
      endcase

      if (cap_result) result <= cap_value;

      // BCD digits order the same as binary, so a plain compare finds the lower score.
      if (bus.clear_best)
        best <= BEST_RESET;
      else if (cap_result && !cap_timeout && (cap_value < best))
        best <= cap_value;

      if (bus.hs_switch) begin
        disp_q <= {BLANK3, best};
        dp_q   <= 1'b0;
      end else if (bus.gb_switch) begin
        disp_q <= bus.gb_bcd;
        dp_q   <= 1'b1;
      end else begin
        disp_q <= {BLANK3, (state == TIMING) ? bus.score_bcd : result};
        dp_q   <= 1'b0;
      end
    end
  end

  assign bus.timer_clr  = timer_clr_q;
  assign bus.timer_en   = timer_en_q;
  assign bus.round_done = round_done_q;
  assign bus.timeout    = timeout_q;
  assign bus.LED        = led_q;
  assign bus.best_bcd   = best;
  assign bus.disp_bcd   = disp_q;
  assign bus.decimal_pt = dp_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: display vector table plus round sequences.
module tb_reaction_round_ctrl;

  localparam int unsigned DMIN = 10;

  logic board_clk = 1'b0;
  logic reset     = 1'b0;

  reaction_round_ctrl_if #(.LFSR_W(13)) bus ();

  reaction_round_ctrl #(
    .DELAY_MIN   (DMIN),
    .LFSR_W      (13),
    .TIMEOUT_BCD (12'h999)
  ) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 board_clk = ~board_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        hs;
    logic        gb;
    logic [23:0] gb_bcd;
    logic [23:0] exp_disp;
    logic        exp_dp;
  } disp_vec_t;

  disp_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.tick_1ms = 1'b1;
    cyc();
    bus.tick_1ms = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_pulse();
      cyc();
    end
  endtask

  // Starts a round from IDLE or DONE and runs the pre-delay into TIMING.
  task automatic arm_and_time(input int lfsr);
    bus.lfsr_val  = 13'(lfsr);
    bus.score_bcd = 12'h000;
    pulse_start();
    cyc();
    tick_n(lfsr + DMIN);
    check("arm_timing_en", 32'(bus.timer_en), 32'h1);
  endtask

  initial begin
    vecs[0] = '{hs: 1'b1, gb: 1'b1, gb_bcd: 24'h123456, exp_disp: 24'hFFF234, exp_dp: 1'b0};
    vecs[1] = '{hs: 1'b1, gb: 1'b0, gb_bcd: 24'h123456, exp_disp: 24'hFFF234, exp_dp: 1'b0};
    vecs[2] = '{hs: 1'b0, gb: 1'b1, gb_bcd: 24'h123456, exp_disp: 24'h123456, exp_dp: 1'b1};
    vecs[3] = '{hs: 1'b0, gb: 1'b1, gb_bcd: 24'h987650, exp_disp: 24'h987650, exp_dp: 1'b1};
    vecs[4] = '{hs: 1'b0, gb: 1'b0, gb_bcd: 24'h987650, exp_disp: 24'hFFF234, exp_dp: 1'b0};

    bus.tick_1ms   = 1'b0;
    bus.start      = 1'b0;
    bus.clear_best = 1'b0;
    bus.lfsr_val   = '0;
    bus.score_bcd  = '0;
    bus.gb_bcd     = 24'h123456;
    bus.hs_switch  = 1'b0;
    bus.gb_switch  = 1'b0;

    // Reset state
    cyc(3);
    reset = 1'b1;
    cyc();
    check("rst_best",     32'(bus.best_bcd),   32'h999);
    check("rst_led",      32'(bus.LED),        32'h0);
    check("rst_disp",     32'(bus.disp_bcd),   32'hFFF000);
    check("rst_timer_en", 32'(bus.timer_en),   32'h0);
    check("rst_timeout",  32'(bus.timeout),    32'h0);
    check("rst_dp",       32'(bus.decimal_pt), 32'h0);

    // Round 1: lfsr=5 -> 15 ms pre-delay, response 234
    bus.lfsr_val = 13'd5;
    pulse_start();
    check("arm_timer_clr", 32'(bus.timer_clr), 32'h1);
    cyc();
    check("wait_timer_clr", 32'(bus.timer_clr), 32'h0);
    tick_n(14);
    check("wait14_en",  32'(bus.timer_en), 32'h0);
    check("wait14_led", 32'(bus.LED),      32'h0);
    tick_pulse();
    check("wait15_en", 32'(bus.timer_en), 32'h0);
    cyc();
    check("timing_en",  32'(bus.timer_en), 32'h1);
    check("timing_led", 32'(bus.LED),      32'h3FF);
    bus.score_bcd = 12'h234;
    cyc();
    check("timing_disp", 32'(bus.disp_bcd), 32'hFFF234);
    pulse_start();
    check("r1_done",    32'(bus.round_done), 32'h1);
    check("r1_best",    32'(bus.best_bcd),   32'h234);
    check("r1_led",     32'(bus.LED),        32'h001);
    check("r1_en_off",  32'(bus.timer_en),   32'h0);
    check("r1_timeout", 32'(bus.timeout),    32'h0);
    cyc();
    check("r1_done_pulse", 32'(bus.round_done), 32'h0);
    check("r1_disp",       32'(bus.disp_bcd),   32'hFFF234);

    // Display select table, held in DONE with best=result=234
    for (int i = 0; i < 5; i++) begin
      bus.hs_switch = vecs[i].hs;
      bus.gb_switch = vecs[i].gb;
      bus.gb_bcd    = vecs[i].gb_bcd;
      cyc();
      check($sformatf("disp_vec%0d", i), 32'(bus.disp_bcd),   32'(vecs[i].exp_disp));
      check($sformatf("dp_vec%0d", i),   32'(bus.decimal_pt), 32'(vecs[i].exp_dp));
    end

    // Round 2: slower response, best holds
    arm_and_time(2);
    bus.score_bcd = 12'h300;
    cyc();
    pulse_start();
    check("r2_done", 32'(bus.round_done), 32'h1);
    check("r2_best", 32'(bus.best_bcd),   32'h234);
    check("r2_led",  32'(bus.LED),        32'h001);

    // Round 3: no response until the counter reaches 999
    arm_and_time(0);
    bus.score_bcd = 12'h998;
    cyc();
    check("r3_998_led", 32'(bus.LED), 32'h3FF);
    bus.score_bcd = 12'h999;
    cyc();
    check("r3_timeout", 32'(bus.timeout),    32'h1);
    check("r3_led",     32'(bus.LED),        32'h2AA);
    check("r3_done",    32'(bus.round_done), 32'h1);
    check("r3_best",    32'(bus.best_bcd),   32'h234);

    // Round 4: start on the timeout cycle wins
    arm_and_time(1);
    check("r4_timeout_clr", 32'(bus.timeout), 32'h0);
    bus.score_bcd = 12'h999;
    pulse_start();
    check("r4_timeout", 32'(bus.timeout),    32'h0);
    check("r4_led",     32'(bus.LED),        32'h001);
    check("r4_done",    32'(bus.round_done), 32'h1);
    check("r4_best",    32'(bus.best_bcd),   32'h234);

    // Round 5: clear_best coincides with a better score
    arm_and_time(1);
    bus.score_bcd  = 12'h100;
    bus.clear_best = 1'b1;
    pulse_start();
    bus.clear_best = 1'b0;
    check("r5_done", 32'(bus.round_done), 32'h1);
    check("r5_best", 32'(bus.best_bcd),   32'h999);

    // Round 6: best updates again after clear
    arm_and_time(3);
    bus.score_bcd = 12'h500;
    pulse_start();
    check("r6_best", 32'(bus.best_bcd), 32'h500);

    // Round 7: start three ticks into the pre-delay (lfsr=4 -> 14 ms)
    bus.lfsr_val  = 13'd4;
    bus.score_bcd = 12'h000;
    pulse_start();
    cyc();
    tick_n(3);
    pulse_start();
`ifdef FALSE_START_EN
    check("fs_done",    32'(bus.round_done), 32'h1);
    check("fs_timeout", 32'(bus.timeout),    32'h1);
    check("fs_led",     32'(bus.LED),        32'h2AA);
    check("fs_en",      32'(bus.timer_en),   32'h0);
    check("fs_best",    32'(bus.best_bcd),   32'h500);
    cyc();
    check("fs_disp",    32'(bus.disp_bcd),   32'hFFF999);
    pulse_start();
    cyc();
    tick_n(2);
`else
    check("nofs_done",    32'(bus.round_done), 32'h0);
    check("nofs_led",     32'(bus.LED),        32'h0);
    check("nofs_timeout", 32'(bus.timeout),    32'h0);
    check("nofs_en",      32'(bus.timer_en),   32'h0);
    tick_n(10);
    check("nofs_wait_en", 32'(bus.timer_en), 32'h0);
    tick_n(1);
    check("nofs_timing_en", 32'(bus.timer_en), 32'h1);
    bus.score_bcd = 12'h050;
    cyc();
`endif

    // Reset mid-round: immediate return, best lost
    reset = 1'b0;
    #1;
    check("mid_rst_best", 32'(bus.best_bcd),   32'h999);
    check("mid_rst_led",  32'(bus.LED),        32'h0);
    check("mid_rst_en",   32'(bus.timer_en),   32'h0);
    check("mid_rst_disp", 32'(bus.disp_bcd),   32'hFFF000);
    check("mid_rst_done", 32'(bus.round_done), 32'h0);
    cyc();
    reset = 1'b1;
    bus.score_bcd = 12'h000;
    cyc();
    pulse_start();
    check("post_rst_arm", 32'(bus.timer_clr), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
